rom_port_arbiter: RTL and testbench

//  Shares one synchronous-read port of the dual-port boot ROM between the

---
 rtl/rom_port_arbiter_pkg.sv | 24 ++
 rtl/rom_port_arbiter_if.sv | 32 +++
 rtl/rom_port_arbiter_slot.sv | 70 +++++++
 rtl/rom_port_arbiter.sv | 77 +++++++
 tb/tb_rom_port_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// Shared types for the boot-ROM port arbiter: slot state encodings, ROM geometry, window test.
// No timing of its own; the slot FSM and arbiter import these.
package rom_port_arbiter_pkg;

  localparam int ROM_AW = 9;
  localparam int ROM_DW = 32;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_PEND = 2'd1,
    SLOT_FULL = 2'd2
  } slot_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } port_t;

  // Any set bit above the ROM word-address field puts the access outside the boot window.
  function automatic logic out_of_window(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Requester handshakes and the shared ROM read port; slave = arbiter side, master = core/ROM side.
// Combinational bundle, no latency; backpressure is carried by i_rdy/d_rdy.
interface rom_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_gnt;
  logic          i_valid;
  logic          i_rdy;
  logic [DW-1:0] i_data;
  logic          d_req;
  logic [31:0]   d_addr;
  logic          d_gnt;
  logic          d_valid;
  logic          d_rdy;
  logic [DW-1:0] d_data;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_do;

  modport slave (
    input  i_req, i_addr, i_rdy, d_req, d_addr, d_rdy, rom_do,
    output i_gnt, i_valid, i_data, d_gnt, d_valid, d_data, rom_en, rom_addr
  );

  modport master (
    output i_req, i_addr, i_rdy, d_req, d_addr, d_rdy, rom_do,
    input  i_gnt, i_valid, i_data, d_gnt, d_valid, d_data, rom_en, rom_addr
  );
endinterface

// File: rtl/rom_port_arbiter_slot.sv
// Per-requester response slot: captures one ROM read, presenting it 2 cycles after grant.
// Holds valid/data until rdy; eligible again only when empty or draining in the same cycle.
module rom_resp_slot
  import rom_port_arbiter_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic          gnt_i,
  input  logic          rdy_i,
  input  logic          zero_i,
  input  logic [DW-1:0] rom_do_i,
  output logic          elig_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  slot_state_t   state_q, state_d;
  logic          zero_q, zero_d;
  logic [DW-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_IDLE;
      zero_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      zero_q  <= zero_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    zero_d  = zero_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_IDLE: begin
        if (gnt_i) begin
          state_d = SLOT_PEND;
          zero_d  = zero_i;
        end
      end
      SLOT_PEND: begin
        // ROM output is valid this cycle; zero_q marks a read that never enabled the ROM.
        state_d = SLOT_FULL;
        data_d  = zero_q ? '0 : rom_do_i;
      end
      SLOT_FULL: begin
        if (rdy_i) begin
          if (gnt_i) begin
            state_d = SLOT_PEND;
            zero_d  = zero_i;
          end else begin
            state_d = SLOT_IDLE;
          end
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  assign elig_o  = req_i & ((state_q == SLOT_IDLE) | ((state_q == SLOT_FULL) & rdy_i));
  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous ROM read port between fetch and data requesters, round-robin on conflict.
// Grant same cycle as req, response valid 2 cycles later; a full slot blocks its port until rdy.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int AW        = ROM_AW,
  parameter int DW        = ROM_DW,
  parameter int IDLE_ZERO = 1
) (
  input  logic               clk,
  input  logic               rst,
  rom_port_arbiter_if.slave  bus
);

  logic  i_elig, d_elig;
  logic  i_gnt, d_gnt;
  logic  i_zero, d_zero;
  port_t last_q, last_d;

  assign i_zero = (IDLE_ZERO != 0) && out_of_window(bus.i_addr, AW);
  assign d_zero = (IDLE_ZERO != 0) && out_of_window(bus.d_addr, AW);

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (i_elig && d_elig) begin
        i_gnt = (last_q == GNT_D);
        d_gnt = (last_q == GNT_I);
      end else begin
        i_gnt = i_elig;
        d_gnt = d_elig;
      end
    end
    last_d = last_q;
    if (i_gnt)      last_d = GNT_I;
    else if (d_gnt) last_d = GNT_D;
  end

  // Reset to D so the first conflict after reset goes to fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= GNT_D;
    else     last_q <= last_d;
  end

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.rom_en   = (i_gnt & ~i_zero) | (d_gnt & ~d_zero);
  assign bus.rom_addr = d_gnt ? bus.d_addr[AW+1:2] : bus.i_addr[AW+1:2];

  rom_resp_slot #(.DW(DW)) u_i_slot (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus.i_req),
    .gnt_i    (i_gnt),
    .rdy_i    (bus.i_rdy),
    .zero_i   (i_zero),
    .rom_do_i (bus.rom_do),
    .elig_o   (i_elig),
    .valid_o  (bus.i_valid),
    .data_o   (bus.i_data)
  );

  rom_resp_slot #(.DW(DW)) u_d_slot (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus.d_req),
    .gnt_i    (d_gnt),
    .rdy_i    (bus.d_rdy),
    .zero_i   (d_zero),
    .rom_do_i (bus.rom_do),
    .elig_o   (d_elig),
    .valid_o  (bus.d_valid),
    .data_o   (bus.d_data)
  );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: stimulus pushes expected read data, a monitor pops on each handshake.
module tb_rom_port_arbiter;
  import rom_port_arbiter_pkg::*;

  localparam int AW = ROM_AW;
  localparam int DW = ROM_DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  rom_port_arbiter #(.AW(AW), .DW(DW), .IDLE_ZERO(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] rom [2**AW];
  always @(posedge clk) if (bus.rom_en) bus.rom_do <= rom[bus.rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_resp_i = 0;
  int n_resp_d = 0;
  logic [DW-1:0] exp_i[$];
  logic [DW-1:0] exp_d[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.i_valid && bus.i_rdy) begin
        n_resp_i++;
        if (exp_i.size() == 0) check("i unexpected response", 32'(bus.i_data), 32'hDEAD_BEEF);
        else check("i response data", 32'(bus.i_data), 32'(exp_i.pop_front()));
      end
      if (bus.d_valid && bus.d_rdy) begin
        n_resp_d++;
        if (exp_d.size() == 0) check("d unexpected response", 32'(bus.d_data), 32'hDEAD_BEEF);
        else check("d response data", 32'(bus.d_data), 32'(exp_d.pop_front()));
      end
      if (bus.rom_en) check("rom_en without gnt", 32'(bus.i_gnt | bus.d_gnt), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit dport, output int gcyc);
    gcyc = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dport ? bus.d_gnt : bus.i_gnt) begin
        gcyc = cyc;
        return;
      end
      step();
    end
    check(dport ? "d gnt timeout" : "i gnt timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " i_gnt"},   32'(bus.i_gnt),   32'd0);
    check({tag, " d_gnt"},   32'(bus.d_gnt),   32'd0);
    check({tag, " rom_en"},  32'(bus.rom_en),  32'd0);
    check({tag, " i_valid"}, 32'(bus.i_valid), 32'd0);
    check({tag, " d_valid"}, 32'(bus.d_valid), 32'd0);
    check({tag, " i_data"},  32'(bus.i_data),  32'd0);
    check({tag, " d_data"},  32'(bus.d_data),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    logic [31:0] ia, da;
    for (int n = 0; n < 2**AW; n++) rom[n] = 32'hA5A5_0000 | 32'(n);
    bus.rom_do = '0;
    bus.i_req = 1'b1; bus.i_addr = 32'h8; bus.i_rdy = 1'b1;
    bus.d_req = 1'b0; bus.d_addr = 32'h0; bus.d_rdy = 1'b1;

    // Reset state, with a pending fetch request that must stay ungranted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    step();
    rst = 1'b0;

    // 1: single fetch of word 2.
    wait_gnt(0, g);
    check("t1 rom_addr", 32'(bus.rom_addr), 32'd2);
    check("t1 rom_en", 32'(bus.rom_en), 32'd1);
    exp_i.push_back(32'hA5A5_0002);
    step();
    bus.i_req = 1'b0;
    @(negedge clk); check("t1 valid t+1", 32'(bus.i_valid), 32'd0);
    @(negedge clk); check("t1 valid t+2", 32'(bus.i_valid), 32'd1);
    @(negedge clk); check("t1 valid t+3", 32'(bus.i_valid), 32'd0);

    // 4: out-of-window data read returns zero without enabling the ROM.
    step();
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_1000;
    wait_gnt(1, g);
    check("t4 rom_en", 32'(bus.rom_en), 32'd0);
    exp_d.push_back(32'h0);
    step();
    bus.d_req = 1'b0;
    @(negedge clk); check("t4 valid t+1", 32'(bus.d_valid), 32'd0);
    @(negedge clk); check("t4 valid t+2", 32'(bus.d_valid), 32'd1);
    check("t4 data", 32'(bus.d_data), 32'h0);
    @(negedge clk);

    // 3: backpressure holds data and blocks re-grant until rdy.
    step();
    bus.d_rdy = 1'b0; bus.d_req = 1'b1; bus.d_addr = 32'h10;
    wait_gnt(1, g);
    exp_d.push_back(32'hA5A5_0004);
    step();
    @(negedge clk); check("t3 no regrant pend", 32'(bus.d_gnt), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3 hold valid", 32'(bus.d_valid), 32'd1);
      check("t3 hold data", 32'(bus.d_data), 32'hA5A5_0004);
      check("t3 no regrant full", 32'(bus.d_gnt), 32'd0);
    end
    step();
    bus.d_rdy = 1'b1;
    @(negedge clk);
    check("t3 regrant on rdy", 32'(bus.d_gnt), 32'd1);
    if (bus.d_gnt) exp_d.push_back(32'hA5A5_0004);
    step();
    bus.d_req = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t3 second valid", 32'(bus.d_valid), 32'd1);

    // 2: simultaneous requests, fetch wins first since data was granted last.
    step();
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_addr = 32'h4;
    @(negedge clk);
    check("t2 first i_gnt", 32'(bus.i_gnt), 32'd1);
    check("t2 first d_gnt", 32'(bus.d_gnt), 32'd0);
    if (bus.i_gnt) exp_i.push_back(32'hA5A5_0000);
    step();
    bus.i_req = 1'b0;
    @(negedge clk);
    check("t2 second d_gnt", 32'(bus.d_gnt), 32'd1);
    check("t2 second i_gnt", 32'(bus.i_gnt), 32'd0);
    if (bus.d_gnt) exp_d.push_back(32'hA5A5_0001);
    step();
    bus.d_req = 1'b0;
    @(negedge clk);
    check("t2 i_valid t+2", 32'(bus.i_valid), 32'd1);
    check("t2 d_valid t+2", 32'(bus.d_valid), 32'd0);
    @(negedge clk);
    check("t2 d_valid t+3", 32'(bus.d_valid), 32'd1);
    check("t2 i_valid t+3", 32'(bus.i_valid), 32'd0);

    // 5: reset mid-read discards the in-flight fetch.
    step();
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    wait_gnt(0, g);
    step();
    bus.i_req = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("t5 in reset");
    exp_i.delete();
    exp_d.delete();
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5 no late valid", 32'(bus.i_valid), 32'd0);
    end

    // 6: both ports streaming, grants alternate starting with fetch.
    step();
    n_resp_i = 0; n_resp_d = 0;
    ia = 32'h0; da = 32'h40;
    bus.i_req = 1'b1; bus.i_addr = ia;
    bus.d_req = 1'b1; bus.d_addr = da;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t6 rom_en", 32'(bus.rom_en), 32'd1);
      check("t6 one grant", 32'(bus.i_gnt ^ bus.d_gnt), 32'd1);
      check("t6 grant port", 32'(bus.d_gnt), 32'(k % 2));
      if (bus.i_gnt) exp_i.push_back(32'hA5A5_0000 | (ia >> 2));
      if (bus.d_gnt) exp_d.push_back(32'hA5A5_0000 | (da >> 2));
      step();
      if (bus.i_req && k % 2 == 0) begin ia = ia + 32'd4; bus.i_addr = ia; end
      if (bus.d_req && k % 2 == 1) begin da = da + 32'd4; bus.d_addr = da; end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (4) @(negedge clk);
    check("t6 i responses", 32'(n_resp_i), 32'd10);
    check("t6 d responses", 32'(n_resp_d), 32'd10);
    check("t6 i queue drained", 32'(exp_i.size()), 32'd0);
    check("t6 d queue drained", 32'(exp_d.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
